// File: rtl/lcd_clk_divider.sv
// Multi-channel programmable clock-enable generator with per-channel phase,
// glitch-free runtime divide reprogramming and a post-reset lock sequence.
module lcd_clk_divider #(
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = 8,
  parameter int DIV_RESET   = 2,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LK_W       = $clog2(LOCK_CYCLES) + 1
) (
  input  logic                i_refclk,
  input  logic                i_reset,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [CH_W-1:0]     i_cfg_ch,
  input  logic [DIV_W-1:0]    i_cfg_div,
  input  logic [DIV_W-1:0]    i_cfg_phase,
  input  logic                i_cfg_sync,
  output logic                o_locked,
  output logic [CHANNELS-1:0] o_clk_en_out,
  output logic [CHANNELS-1:0] o_clk_sq_out
);

  logic [LK_W-1:0]     r_lock_cnt;
  logic                r_locked;

  logic                r_pend_valid;
  logic [CH_W-1:0]     r_pend_ch;
  logic [DIV_W-1:0]    r_pend_div;
  logic [DIV_W-1:0]    r_pend_phase;
  logic                r_pend_sync;

  logic [CH_W:0]       w_cfg_ch_ext;
  logic                w_ch_ok;
  logic                w_accept;
  logic [CHANNELS-1:0] w_apply_ch;
  logic                w_apply;
  logic                w_sync_apply;

  // Lock sequence: counter stops once locked, locked holds until reset.
  always_ff @(posedge i_refclk or posedge i_reset) begin
    if (i_reset) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (!r_locked) begin
      r_lock_cnt <= r_lock_cnt + LK_W'(1);
      if (r_lock_cnt == LK_W'(LOCK_CYCLES - 1)) begin
        r_locked <= 1'b1;
      end
    end
  end

  assign o_locked = r_locked;

  // Writes to a nonexistent channel complete the handshake but are dropped.
  assign w_cfg_ch_ext = {1'b0, i_cfg_ch};
  assign w_ch_ok      = (w_cfg_ch_ext < (CH_W + 1)'(CHANNELS));
  assign o_cfg_ready  = !r_pend_valid;
  assign w_accept     = i_cfg_valid && o_cfg_ready && w_ch_ok;
  assign w_apply      = |w_apply_ch;
  assign w_sync_apply = w_apply && r_pend_sync;

  always_ff @(posedge i_refclk or posedge i_reset) begin
    if (i_reset) begin
      r_pend_valid <= 1'b0;
      r_pend_ch    <= '0;
      r_pend_div   <= '0;
      r_pend_phase <= '0;
      r_pend_sync  <= 1'b0;
    end else if (w_apply) begin
      r_pend_valid <= 1'b0;
    end else if (w_accept) begin
      r_pend_valid <= 1'b1;
      r_pend_ch    <= i_cfg_ch;
      r_pend_div   <= i_cfg_div;
      r_pend_phase <= i_cfg_phase;
      r_pend_sync  <= i_cfg_sync;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DIV_W-1:0] r_div;
      logic [DIV_W-1:0] r_phase;
      logic [DIV_W-1:0] r_cnt;
      logic [DIV_W-1:0] w_cnt_next;
      logic [DIV_W-1:0] w_last;
      logic [DIV_W-1:0] w_ph;
      logic             w_div_one;
      logic             w_div_multi;
      logic             w_at_last;

      assign w_last      = r_div - DIV_W'(1);
      assign w_ph        = (r_phase > w_last) ? w_last : r_phase;
      assign w_div_one   = (r_div == DIV_W'(1));
      assign w_div_multi = (r_div >= DIV_W'(2));
      assign w_at_last   = w_div_multi && (r_cnt == w_last);

      // Switching only at a period boundary (or when idle/unlocked) avoids runt periods.
      assign w_apply_ch[gi] = r_pend_valid && (r_pend_ch == CH_W'(gi)) &&
                              (!r_locked || !w_div_multi || w_at_last);

      always_comb begin
        w_cnt_next = r_cnt + DIV_W'(1);
        if (!r_locked || !w_div_multi || w_at_last || w_apply_ch[gi] || w_sync_apply) begin
          w_cnt_next = '0;
        end
      end

      always_ff @(posedge i_refclk or posedge i_reset) begin
        if (i_reset) begin
          r_div   <= DIV_W'(DIV_RESET);
          r_phase <= '0;
          r_cnt   <= '0;
        end else begin
          r_cnt <= w_cnt_next;
          if (w_apply_ch[gi]) begin
            r_div   <= r_pend_div;
            r_phase <= r_pend_phase;
          end
        end
      end

      assign o_clk_en_out[gi] = r_locked && (w_div_one || (w_div_multi && (r_cnt == w_ph)));
      assign o_clk_sq_out[gi] = r_locked && (w_div_one || (w_div_multi && (r_cnt < (r_div >> 1))));
    end
  endgenerate

endmodule

// File: tb/tb_lcd_clk_divider.sv
// Self-checking bench for lcd_clk_divider: cycle scoreboard against a reference
// model plus directed checks on lock timing, apply latency, phase and sync.
module tb_lcd_clk_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       v;
  logic [1:0] ch;
  logic [7:0] dv;
  logic [7:0] ph;
  logic       sy;
  logic       ready;
  logic       locked;
  logic [3:0] en;
  logic [3:0] sq;

  // Second instance with 3 channels so an out-of-range channel is encodable.
  logic       v_b;
  logic [1:0] ch_b;
  logic [7:0] dv_b;
  logic       ready_b;
  logic       locked_b;
  logic [2:0] en_b;
  logic [2:0] sq_b;

  always #5 clk = ~clk;

  lcd_clk_divider #(.CHANNELS(4), .DIV_W(8), .DIV_RESET(2), .LOCK_CYCLES(16)) dut (
    .i_refclk     (clk),
    .i_reset      (rst),
    .i_cfg_valid  (v),
    .o_cfg_ready  (ready),
    .i_cfg_ch     (ch),
    .i_cfg_div    (dv),
    .i_cfg_phase  (ph),
    .i_cfg_sync   (sy),
    .o_locked     (locked),
    .o_clk_en_out (en),
    .o_clk_sq_out (sq)
  );

  lcd_clk_divider #(.CHANNELS(3), .DIV_W(8), .DIV_RESET(2), .LOCK_CYCLES(1)) dut_b (
    .i_refclk     (clk),
    .i_reset      (rst),
    .i_cfg_valid  (v_b),
    .o_cfg_ready  (ready_b),
    .i_cfg_ch     (ch_b),
    .i_cfg_div    (dv_b),
    .i_cfg_phase  (8'd0),
    .i_cfg_sync   (1'b0),
    .o_locked     (locked_b),
    .o_clk_en_out (en_b),
    .o_clk_sq_out (sq_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  int m_div[4];
  int m_ph[4];
  int m_cnt[4];
  bit m_lk;
  int m_lcnt;
  bit m_pend;
  int m_pch;
  int m_pdiv;
  int m_pph;
  bit m_psync;

  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_div[i] = 2;
      m_ph[i]  = 0;
      m_cnt[i] = 0;
    end
    m_lk = 0; m_lcnt = 0; m_pend = 0;
    m_pch = 0; m_pdiv = 0; m_pph = 0; m_psync = 0;
  endfunction

  function automatic void model_step();
    int ncnt[4];
    bit app;
    bit acc;
    app = m_pend && (!m_lk || m_div[m_pch] <= 1 || m_cnt[m_pch] == m_div[m_pch] - 1);
    acc = v && !m_pend;
    for (int i = 0; i < 4; i++) begin
      if (!m_lk || m_div[i] < 2) ncnt[i] = 0;
      else ncnt[i] = (m_cnt[i] + 1) % m_div[i];
    end
    if (app) begin
      m_div[m_pch] = m_pdiv;
      m_ph[m_pch]  = m_pph;
      ncnt[m_pch]  = 0;
      if (m_psync) for (int i = 0; i < 4; i++) ncnt[i] = 0;
      m_pend = 0;
    end else if (acc && int'(ch) < 4) begin
      m_pend = 1; m_pch = int'(ch); m_pdiv = int'(dv); m_pph = int'(ph); m_psync = sy;
    end
    for (int i = 0; i < 4; i++) m_cnt[i] = ncnt[i];
    if (!m_lk) begin
      if (m_lcnt == 15) m_lk = 1;
      m_lcnt++;
    end
  endfunction

  function automatic logic [9:0] model_out();
    logic [3:0] e;
    logic [3:0] s;
    int p;
    e = '0;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_lk && m_div[i] == 1) begin
        e[i] = 1'b1;
        s[i] = 1'b1;
      end else if (m_lk && m_div[i] >= 2) begin
        p = (m_ph[i] < m_div[i]) ? m_ph[i] : m_div[i] - 1;
        e[i] = (m_cnt[i] == p);
        s[i] = (m_cnt[i] < m_div[i] / 2);
      end
    end
    return {m_lk, !m_pend, e, s};
  endfunction

  task automatic tick();
    logic [9:0] exp;
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    exp_q.push_back(model_out());
    @(negedge clk);
    cyc++;
    exp = exp_q.pop_front();
    check("scoreboard", {22'd0, locked, ready, en, sq}, {22'd0, exp});
  endtask

  task automatic cfg_write(input int c, input int d, input int p, input int s);
    v = 1'b1; ch = 2'(c); dv = 8'(d); ph = 8'(p); sy = 1'(s);
    $display("cfg_write ch=%0d div=%0d phase=%0d sync=%0d cycle=%0d", c, d, p, s, cyc);
    tick();
    v = 1'b0;
  endtask

  task automatic count_ready_low(output int n);
    n = 0;
    while (!ready && n < 20) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_lock();
    int n;
    n = 0;
    while (!locked && n < 40) begin
      tick();
      n++;
    end
    check("lock_cycle", cyc, 16);
  endtask

  task automatic observe(input int c, input int ncyc, output int off, output int per, output int hi);
    int start;
    int first;
    int second;
    start = cyc; first = -1; second = -1; hi = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (en[c]) begin
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
      if (sq[c]) hi++;
      tick();
    end
    off = (first < 0) ? -1 : first - start;
    per = (second < 0) ? -1 : second - first;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int off;
    int per;
    int hi;
    int acc;
    int full;
    int bad;
    rst = 1'b1; v = 1'b0; ch = '0; dv = '0; ph = '0; sy = 1'b0;
    v_b = 1'b0; ch_b = '0; dv_b = '0;
    model_reset();
    #1;
    check("rst_locked", locked, 0);
    check("rst_ready", ready, 1);
    check("rst_en", en, 0);
    check("rst_sq", sq, 0);
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;

    // Lock and default divide-by-2 pattern
    wait_lock();
    check("lock_en", en, 4'hF);
    check("lock_sq", sq, 4'hF);
    tick();
    check("c17_en", en, 4'h0);
    check("c17_sq", sq, 4'h0);

    // ch1 div=5 phase=3
    cfg_write(1, 5, 3, 0);
    count_ready_low(n);
    check("wr1_ready_low", n, 2);
    observe(1, 10, off, per, hi);
    check("ch1_phase_off", off, 3);
    check("ch1_period", per, 5);
    check("ch1_sq_high", hi, 4);

    // ch2 div=4 phase=9 clamps to 3
    cfg_write(2, 4, 9, 0);
    count_ready_low(n);
    check("wr2_latency_ok", (n >= 1 && n <= 2), 1);
    observe(2, 8, off, per, hi);
    check("ch2_phase_clamp", off, 3);
    check("ch2_period", per, 4);
    check("ch2_sq_high", hi, 4);

    // ch0 off, then div=3 applies on the next edge
    cfg_write(0, 0, 0, 0);
    count_ready_low(n);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      acc = acc | int'(en[0]) | int'(sq[0]);
      tick();
    end
    check("ch0_off", acc, 0);
    cfg_write(0, 3, 0, 0);
    count_ready_low(n);
    check("div0_apply_lat", n, 1);
    observe(0, 6, off, per, hi);
    check("ch0_phase_off", off, 0);
    check("ch0_period", per, 3);
    check("ch0_sq_high", hi, 2);

    // ch3 div=6 with sync: all counters realign
    cfg_write(3, 6, 0, 1);
    count_ready_low(n);
    check("sync_en", en, 4'b1001);
    check("sync_sq", sq, 4'hF);

    // Reset while a write is pending
    cfg_write(1, 7, 0, 0);
    check("pend_before_rst", ready, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_locked", locked, 0);
    check("arst_ready", ready, 1);
    check("arst_en", en, 0);
    check("arst_sq", sq, 0);
    tick();
    rst = 1'b0;
    cyc = 0;
    wait_lock();
    observe(1, 4, off, per, hi);
    check("ch1_after_rst_off", off, 0);
    check("ch1_after_rst_period", per, 2);
    check("ch1_after_rst_sq", hi, 2);

    // Out-of-range channel on the 3-channel instance
    v_b = 1'b1; ch_b = 2'd3; dv_b = 8'd5;
    $display("cfg_write(b) ch=3 div=5 cycle=%0d", cyc);
    full = 0; bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("inv_ch_ready", ready_b, 1);
      if (en_b == 3'b111) full++;
      else if (en_b != 3'b000) bad++;
    end
    v_b = 1'b0;
    check("inv_ch_en_full", full, 2);
    check("inv_ch_en_bad", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
